hilo_muldiv: RTL and testbench

//  EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/hilo_muldiv.sv | 170 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// EX-stage multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Stalls the pipeline while a MULT/DIV is in flight; MTHI/MTLO write in a single cycle.
module hilo_muldiv #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [5:0]  alu_control_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, res_hi, res_lo;
    logic [31:0] op_a, op_b;
    logic        op_signed;
    logic [31:0] rem, quo, dvs;
    logic        neg_q, neg_r;

    logic        is_mul, is_div, is_md, div_signed;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ext_a, ext_b, product;
    logic [32:0] shifted, diff;
    logic        q_bit;
    logic [31:0] rem_nx, quo_nx;

    always_comb begin
        is_mul     = (alu_control_i == ALU_MULT) || (alu_control_i == ALU_MULTU);
        is_div     = (alu_control_i == ALU_DIV)  || (alu_control_i == ALU_DIVU);
        is_md      = is_mul || is_div;
        div_signed = (alu_control_i == ALU_DIV);
        a_mag      = (div_signed && a_i[31]) ? -a_i : a_i;
        b_mag      = (div_signed && b_i[31]) ? -b_i : b_i;
    end

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    always_comb begin
        ext_a   = {{32{op_signed & op_a[31]}}, op_a};
        ext_b   = {{32{op_signed & op_b[31]}}, op_b};
        product = ext_a * ext_b;
    end

    // One restoring step: dividend bits enter from the top of quo as quotient bits enter below.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[32];
        rem_nx  = q_bit ? diff[31:0] : shifted[31:0];
        quo_nx  = {quo[30:0], q_bit};
    end

    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en_i && is_mul) begin
                        state_nx = S_MUL;
                    end else if (en_i && is_div) begin
                        state_nx = (b_i == '0) ? S_DONE : S_DIV;
                    end
                end
                S_MUL:   if (cnt == '0) state_nx = S_DONE;
                S_DIV:   if (cnt == 5'd31) state_nx = S_DONE;
                S_DONE:  if (!hold_i) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = en_i & is_md & (state != S_DONE) & ~flush_i;
        busy_o  = (state != S_IDLE);
        hi_o    = hi;
        lo_o    = lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            res_hi    <= '0;
            res_lo    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (en_i && !flush_i) begin
                        if (is_mul) begin
                            op_a      <= a_i;
                            op_b      <= b_i;
                            op_signed <= (alu_control_i == ALU_MULT);
                            cnt       <= 5'(MUL_LAT - 1);
                        end else if (is_div) begin
                            if (b_i == '0) begin
                                res_hi <= a_i;
                                res_lo <= '1;
                            end else begin
                                rem   <= '0;
                                quo   <= a_mag;
                                dvs   <= b_mag;
                                neg_q <= div_signed & (a_i[31] ^ b_i[31]);
                                neg_r <= div_signed & a_i[31];
                                cnt   <= '0;
                            end
                        end else if (alu_control_i == ALU_MTHI) begin
                            hi <= a_i;
                        end else if (alu_control_i == ALU_MTLO) begin
                            lo <= a_i;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        res_hi <= product[63:32];
                        res_lo <= product[31:0];
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        res_lo <= neg_q ? -quo_nx : quo_nx;
                        res_hi <= neg_r ? -rem_nx : rem_nx;
                    end
                end
                S_DONE: begin
                    if (!hold_i && !flush_i) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: expected HI/LO pairs are queued at issue and
// popped for comparison once the operation has committed.
module tb_hilo_muldiv;

    localparam int unsigned MUL_LAT = 2;
    localparam logic [5:0] ALU_ADD   = 6'h20;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst, en, flush, hold;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    hilo_muldiv #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .alu_control_i(op),
        .a_i          (a),
        .b_i          (b),
        .flush_i      (flush),
        .hold_i       (hold),
        .stall_o      (stall),
        .busy_o       (busy),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_head(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " hi"}, hi, e[63:32]);
            check({tag, " lo"}, lo, e[31:0]);
        end
    endtask

    task automatic run_md(input string tag, input logic [5:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int exp_stall, input logic [63:0] exp);
        int n = 0;
        sb.push_back(exp);
        @(negedge clk);
        en = 1'b1; op = o; a = va; b = vb;
        #1;
        while (stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall"}, n, exp_stall);
        check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        en = 1'b0; op = ALU_ADD;
        #1;
        compare_head(tag);
    endtask

    task automatic run_mt(input string tag, input logic [5:0] o, input logic [31:0] va,
                          input logic [63:0] exp);
        sb.push_back(exp);
        @(negedge clk);
        en = 1'b1; op = o; a = va; b = '0;
        #1;
        check({tag, " stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        en = 1'b0; op = ALU_ADD;
        #1;
        compare_head(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; hold = 1'b0; op = ALU_ADD; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);

        run_md("mult",    ALU_MULT,  32'hFFFF_FFFE, 32'd3, 1 + MUL_LAT, 64'hFFFF_FFFF_FFFF_FFFA);
        run_md("multu",   ALU_MULTU, 32'hFFFF_FFFE, 32'd3, 1 + MUL_LAT, 64'h0000_0002_FFFF_FFFA);
        run_md("mult_mn", ALU_MULT,  32'h8000_0000, 32'h8000_0000, 1 + MUL_LAT, 64'h4000_0000_0000_0000);
        run_md("div",     ALU_DIV,   32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("divu",    ALU_DIVU,  32'd7, 32'd2, 33, 64'h0000_0001_0000_0003);
        run_md("div_ovf", ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
        run_md("div_neg", ALU_DIV,   32'd100, 32'hFFFF_FFF9, 33, 64'h0000_0002_FFFF_FFF2);
        run_md("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'd10, 33, 64'h0000_0005_1999_9999);
        run_md("divu_z",  ALU_DIVU,  32'd5, 32'd0, 1, 64'h0000_0005_FFFF_FFFF);

        // Non-md op: no stall, no state change
        @(negedge clk);
        en = 1'b1; op = ALU_ADD; a = 32'h55; b = 32'h66;
        #1;
        check("nonmd stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        en = 1'b0;
        #1;
        check("nonmd busy", {31'd0, busy}, 32'd0);
        check("nonmd lo", lo, 32'hFFFF_FFFF);

        run_mt("mthi", ALU_MTHI, 32'h1234, 64'h0000_1234_FFFF_FFFF);
        run_mt("mtlo", ALU_MTLO, 32'h1234, 64'h0000_1234_0000_1234);

        // Flush in the tenth divide cycle
        @(negedge clk);
        en = 1'b1; op = ALU_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        repeat (10) @(negedge clk);
        #1;
        check("flush_pre busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0; en = 1'b0; op = ALU_ADD;
        #1;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush hi", hi, 32'h1234);
        check("flush lo", lo, 32'h1234);
        repeat (40) @(negedge clk);
        #1;
        check("flush late hi", hi, 32'h1234);
        check("flush late lo", lo, 32'h1234);

        // Flush coinciding with MTHI
        @(negedge clk);
        en = 1'b1; op = ALU_MTHI; a = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        en = 1'b0; op = ALU_ADD; flush = 1'b0;
        #1;
        check("flush_mthi hi", hi, 32'h1234);

        // Hold keeps the result parked in DONE
        hold = 1'b1;
        sb.push_back(64'h0000_0000_0000_002A);
        @(negedge clk);
        en = 1'b1; op = ALU_MULTU; a = 32'd7; b = 32'd6;
        #1;
        for (int i = 0; i < 200 && stall === 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            check("hold hi", hi, 32'h1234);
            check("hold lo", lo, 32'h1234);
            check("hold busy", {31'd0, busy}, 32'd1);
            if (i < 3) begin
                @(negedge clk);
                #1;
            end
        end
        hold = 1'b0;
        @(negedge clk);
        en = 1'b0; op = ALU_ADD;
        #1;
        compare_head("hold_commit");
        check("hold busy_after", {31'd0, busy}, 32'd0);

        // MTLO followed directly by MFLO
        @(negedge clk);
        en = 1'b1; op = ALU_MTLO; a = 32'hABCD;
        @(negedge clk);
        op = ALU_MFLO; a = '0;
        #1;
        check("mflo lo", lo, 32'hABCD);
        check("mflo stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        en = 1'b0; op = ALU_ADD;

        // Reset in the middle of a multiply
        @(negedge clk);
        en = 1'b1; op = ALU_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        #1;
        check("rst_mid busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1; en = 1'b0; op = ALU_ADD;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid stall", {31'd0, stall}, 32'd0);
        check("rst_mid hi", hi, 32'd0);
        check("rst_mid lo", lo, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("rst_mid late lo", lo, 32'd0);
        check("sb drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
